// File: rtl/instr_enc.sv
// instr_enc: packs a signed immediate into an instruction word and emits it with an auto-incrementing byte address.
// Optional macro INSTR_ENC_RANGE_CHECK_EN drops requests whose immediate does not fit its field.
module instr_enc #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ImmSrc,
    input  logic [31:0]       Imm,
    input  logic [31:0]       Base,
    input  logic              addr_load,
    input  logic [31:0]       addr_in,
    input  logic              err_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_addr,
    output logic              err,
    output logic [DROP_W-1:0] drop_cnt
);
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic [31:0]       addr_q, addr_d;
    logic              err_q, err_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]       word_i, word_s, word_b, packed_w;
    logic              range_bad, accept, drop;
    logic              unused_bits;

    assign word_i   = {Imm[11:0], Base[19:0]};
    assign word_s   = {Imm[11:5], Base[24:12], Imm[4:0], Base[6:0]};
    assign word_b   = {Imm[12], Imm[10:5], Base[24:12], Imm[4:1], Imm[11], Base[6:0]};
    assign packed_w = ImmSrc == 2'b00 ? word_i : ImmSrc == 2'b01 ? word_s : word_b;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Upper immediate bits must be a pure sign extension; branch offsets must also be even.
    assign range_bad = ImmSrc == 2'b10
        ? !((&Imm[31:12]) || !(|Imm[31:12])) || Imm[0]
        : !((&Imm[31:11]) || !(|Imm[31:11]));
`else
    assign range_bad = 1'b0;
`endif

    assign unused_bits = ^{Base[31:25], Imm[31:13], Imm[0]};

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drop     = accept && (ImmSrc == 2'b11 || range_bad);

    // Next state: load output register on a good request, track address, error and drop count.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        addr_d      = addr_q;
        err_d       = err_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept && !drop) begin
            out_valid_d = 1'b1;
            out_instr_d = packed_w;
            out_addr_d  = addr_q;
            addr_d      = addr_q + 32'd4;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (addr_load) addr_d = addr_in;
        err_d = drop ? 1'b1 : err_clr ? 1'b0 : err_q;
        if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: vector table, hand sequences and random traffic against a behavioural model of instr_enc.
module tb_instr_enc;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [1:0]  imm_src = 2'b00;
    logic [31:0] imm = '0, base = '0;
    logic        addr_load = 1'b0;
    logic [31:0] addr_in = '0;
    logic        err_clr = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_instr, out_addr;
    logic        err;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    instr_enc #(.DROP_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ImmSrc(imm_src), .Imm(imm), .Base(base), .addr_load(addr_load),
        .addr_in(addr_in), .err_clr(err_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .drop_cnt(drop_cnt)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Behavioural model state
    bit          m_valid;
    logic [31:0] m_instr, m_addr, m_cnt;
    bit          m_err;
    int          m_drop;

    function automatic logic [31:0] pack(input logic [1:0] s, input logic [31:0] b, input logic [31:0] i);
        if (s == 2'd0) return (b & 32'h000F_FFFF) | ((i & 32'hFFF) << 20);
        if (s == 2'd1) return (b & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
        return (b & 32'h01FF_F07F) | (((i >> 12) & 32'd1) << 31) | (((i >> 5) & 32'h3F) << 25)
             | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'd1) << 7);
    endfunction

    function automatic bit is_drop(input logic [1:0] s, input logic [31:0] i);
        int v;
        v = $signed(i);
        if (s == 2'd3) return 1'b1;
        if (!RC) return 1'b0;
        if (s == 2'd2) return v < -4096 || v > 4094 || (v % 2) != 0;
        return v < -2048 || v > 2047;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_instr = '0; m_addr = '0; m_cnt = '0; m_err = 0; m_drop = 0;
    endfunction

    // One clock: compare at negedge, advance model, return at posedge+1.
    task automatic cyc();
        bit acc, bad;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_addr", out_addr, m_addr);
        end
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
        acc = in_valid && (!m_valid || out_ready);
        bad = acc && is_drop(imm_src, imm);
        if (acc && !bad) begin
            m_valid = 1; m_instr = pack(imm_src, base, imm); m_addr = m_cnt; m_cnt = m_cnt + 4;
        end else if (out_ready) m_valid = 0;
        if (addr_load) m_cnt = addr_in;
        if (bad) m_err = 1; else if (err_clr) m_err = 0;
        if (bad && m_drop < 255) m_drop++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; addr_load = 0; err_clr = 0; out_ready = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst = 0;
        model_reset();
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic req(input logic [1:0] s, input logic [31:0] b, input logic [31:0] i);
        in_valid = 1; imm_src = s; base = b; imm = i;
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [31:0] base, imm, exp_instr;
        bit          drop;
    } vec_t;

    initial begin
        vec_t tv[13];
        logic [31:0] ea, w0;
        int nd;
        tv[0]  = '{2'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0};
        tv[1]  = '{2'd1, 32'h0000_2023, 32'h0000_0024, 32'h0200_2223, 1'b0};
        tv[2]  = '{2'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        tv[3]  = '{2'd0, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, RC};
        tv[4]  = '{2'd3, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tv[5]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h000F_FFFF, 1'b0};
        tv[6]  = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h01FF_F07F, 1'b0};
        tv[7]  = '{2'd2, 32'h0000_0000, 32'h0000_0FFE, 32'h7E00_0F80, 1'b0};
        tv[8]  = '{2'd2, 32'h0000_0000, 32'hFFFF_F000, 32'h8000_0000, 1'b0};
        tv[9]  = '{2'd0, 32'h0000_0000, 32'h0000_07FF, 32'h7FF0_0000, 1'b0};
        tv[10] = '{2'd0, 32'h0000_0000, 32'hFFFF_F800, 32'h8000_0000, 1'b0};
        tv[11] = '{2'd2, 32'h0000_0063, 32'h0000_0001, 32'h0000_0063, RC};
        tv[12] = '{2'd1, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000, RC};

        do_reset();
        ea = 0; nd = 0;
        foreach (tv[k]) begin
            req(tv[k].src, tv[k].base, tv[k].imm);
            cyc();
            chk($sformatf("vec%0d_valid", k), {31'd0, out_valid}, {31'd0, !tv[k].drop});
            if (tv[k].drop) begin
                nd++;
                chk($sformatf("vec%0d_err", k), {31'd0, err}, 32'd1);
            end else begin
                chk($sformatf("vec%0d_instr", k), out_instr, tv[k].exp_instr);
                chk($sformatf("vec%0d_addr", k), out_addr, ea);
                ea += 4;
            end
            chk($sformatf("vec%0d_drops", k), {24'd0, drop_cnt}, nd);
            in_valid = 0; err_clr = 1;
            cyc();
            err_clr = 0;
        end

        // err_clr coinciding with a drop keeps err set
        req(2'd3, 32'h0, 32'h0); err_clr = 1;
        cyc();
        in_valid = 0; err_clr = 0;
        chk("clr_vs_drop_err", {31'd0, err}, 32'd1);
        cyc();

        // Backpressure: two requests, consumer stalled for three cycles
        do_reset();
        out_ready = 0;
        req(2'd0, 32'h13, 32'h1);
        cyc();
        w0 = out_instr;
        chk("bp_first_word", w0, 32'h0010_0013);
        req(2'd0, 32'h13, 32'h2);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_instr", out_instr, w0);
            chk("bp_hold_addr", out_addr, 32'd0);
        end
        out_ready = 1;
        cyc();
        in_valid = 0;
        chk("bp_second_instr", out_instr, 32'h0020_0013);
        chk("bp_second_addr", out_addr, 32'd4);
        cyc();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Address load, wrap, load racing an accept, then async reset with a held word
        do_reset();
        addr_load = 1; addr_in = 32'hFFFF_FFFC;
        cyc();
        addr_load = 0;
        req(2'd0, 32'h13, 32'h0);
        cyc();
        chk("wrap_addr0", out_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr1", out_addr, 32'h0);
        addr_load = 1; addr_in = 32'h100;
        cyc();
        addr_load = 0;
        chk("load_race_old", out_addr, 32'h4);
        cyc();
        chk("load_race_new", out_addr, 32'h100);
        out_ready = 0; in_valid = 0;
        cyc();
        #2 rst = 1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_addr", out_addr, 32'd0);
        do_reset();

        // Drop counter saturation
        req(2'd3, 32'h0, 32'h0);
        repeat (260) cyc();
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            imm_src   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            base      = $urandom;
            imm       = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 10000)) - 5000);
            addr_load = ($urandom_range(0, 49) == 0);
            addr_in   = $urandom;
            err_clr   = ($urandom_range(0, 19) == 0);
            cyc();
        end
        in_valid = 0; addr_load = 0; err_clr = 0; out_ready = 1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
